// File: rtl/var_delay_line.sv
// ----------------------------------------------------------------------------
// var_delay_line
//
// Runtime-selectable delay line for aligning data streams that pass through
// pipelines of differing latency (pixel data vs. sync, video vs. audio, ...).
// Up to MAXDELAY storage stages, each carrying WDATA data bits plus a valid
// bit. The line advances only when CE is high. The output tap is selected by
// a registered copy of SEL, clamped to [1, MAXDELAY], and is a pure
// combinational mux off the stage registers (no extra output register).
//
// Ports:
//   CLK        in   1      clock, all state updates on the rising edge
//   RST        in   1      synchronous active-high reset (priority over CE)
//   CE         in   1      advance enable; stages shift only when high
//   IN         in   WDATA  input data
//   VALID_IN   in   1      qualifies IN
//   SEL        in   WSEL   requested delay in CE cycles (registered first)
//   OUT        out  WDATA  delayed data, stage[D-1]
//   VALID_OUT  out  1      valid bit travelling with OUT
//   PRIMED     out  1      high once at least D CE-advances since reset
//   D_EFF      out  WSEL   effective (clamped) delay currently applied
// ----------------------------------------------------------------------------
module var_delay_line #(
    parameter int WDATA    = 8,
    parameter int MAXDELAY = 16,
    parameter int WSEL     = $clog2(MAXDELAY + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WDATA-1:0] IN,
    input  logic             VALID_IN,
    input  logic [WSEL-1:0]  SEL,
    output logic [WDATA-1:0] OUT,
    output logic             VALID_OUT,
    output logic             PRIMED,
    output logic [WSEL-1:0]  D_EFF
);

    localparam logic [WSEL-1:0] MAX_TAP = WSEL'(MAXDELAY);
    localparam logic [WSEL-1:0] ONE     = WSEL'(1);

    // Tap selection: 0 means "as short as possible", oversize means "as long
    // as the line allows".
    function automatic logic [WSEL-1:0] clamp_delay(input logic [WSEL-1:0] s);
        if (s == '0) begin
            return ONE;
        end
        if (s > MAX_TAP) begin
            return MAX_TAP;
        end
        return s;
    endfunction

    logic [WDATA-1:0] stage_data [MAXDELAY];
    logic [MAXDELAY-1:0] stage_vld;
    logic [WSEL-1:0]  sel_q;
    logic [WSEL-1:0]  cnt;
    logic [WSEL-1:0]  d_eff;
    logic [WSEL-1:0]  tap_idx;

    // ---- storage stages, fill counter and SEL register ----
    // Data stages are cleared on reset too, so a delay increase right after
    // reset replays zeros rather than stale words.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < MAXDELAY; i++) begin
                stage_data[i] <= '0;
            end
            stage_vld <= '0;
            cnt       <= '0;
            sel_q     <= '0;
        end else begin
            // SEL is sampled every cycle, independent of CE.
            sel_q <= SEL;
            if (CE) begin
                stage_data[0] <= IN;
                stage_vld[0]  <= VALID_IN;
                for (int i = 1; i < MAXDELAY; i++) begin
                    stage_data[i] <= stage_data[i-1];
                    stage_vld[i]  <= stage_vld[i-1];
                end
                if (cnt != MAX_TAP) begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

    // ---- combinational output tap ----
    // The tap moves immediately with sel_q; stage contents are never touched,
    // so a delay change replays or skips samples and downstream must rely on
    // VALID_OUT / PRIMED.
    always_comb begin
        d_eff     = clamp_delay(sel_q);
        tap_idx   = d_eff - ONE;
        OUT       = '0;
        VALID_OUT = 1'b0;
        for (int i = 0; i < MAXDELAY; i++) begin
            if (tap_idx == WSEL'(i)) begin
                OUT       = stage_data[i];
                VALID_OUT = stage_vld[i];
            end
        end
    end

    assign PRIMED = (cnt >= d_eff);
    assign D_EFF  = d_eff;

endmodule

// File: tb/tb_var_delay_line.sv
// ----------------------------------------------------------------------------
// tb_var_delay_line
//
// Self-checking bench for var_delay_line (WDATA=8, MAXDELAY=16). Captured
// words are pushed into a scoreboard queue on every CE=1 edge; once the queue
// holds D entries the oldest one is the word that must sit on the tap.
// ----------------------------------------------------------------------------
module tb_var_delay_line;

    localparam int WDATA    = 8;
    localparam int MAXDELAY = 16;
    localparam int WSEL     = $clog2(MAXDELAY + 1);

    logic             CLK;
    logic             RST;
    logic             CE;
    logic [WDATA-1:0] IN;
    logic             VALID_IN;
    logic [WSEL-1:0]  SEL;
    logic [WDATA-1:0] OUT;
    logic             VALID_OUT;
    logic             PRIMED;
    logic [WSEL-1:0]  D_EFF;

    var_delay_line #(
        .WDATA   (WDATA),
        .MAXDELAY(MAXDELAY)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .IN       (IN),
        .VALID_IN (VALID_IN),
        .SEL      (SEL),
        .OUT      (OUT),
        .VALID_OUT(VALID_OUT),
        .PRIMED   (PRIMED),
        .D_EFF    (D_EFF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard: {data, valid} of captured words, and the word due on the tap.
    logic [WDATA:0] sb [$];
    logic [WDATA:0] exp_tap;
    int             fill;
    int             d_cur;

    function automatic int clamp_sel(input int s);
        if (s < 1) return 1;
        if (s > MAXDELAY) return MAXDELAY;
        return s;
    endfunction

    task automatic clear_model();
        sb.delete();
        exp_tap = '0;
        fill    = 0;
        d_cur   = 1;
    endtask

    // One clock edge with the given inputs; outputs are sampled 1 unit later.
    task automatic edge_cycle(input logic ce, input logic [WDATA-1:0] din, input logic vin);
        CE       = ce;
        IN       = din;
        VALID_IN = vin;
        @(posedge CLK);
        #1;
        if (ce) begin
            sb.push_back({din, vin});
            if (fill < MAXDELAY) fill++;
            if (sb.size() >= d_cur) exp_tap = sb.pop_front();
        end
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        CE       = 1'b1;
        IN       = 8'h55;
        VALID_IN = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        CE  = 1'b0;
        clear_model();
    endtask

    task automatic set_sel(input int s);
        SEL = WSEL'(s);
        CE  = 1'b0;
        @(posedge CLK);
        #1;
        d_cur = clamp_sel(s);
    endtask

    task automatic test_reset();
        SEL = '0;
        do_reset();
        vectors++;
        if (OUT !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out: got %h want 00", OUT);
        end
        vectors++;
        if (VALID_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 0", VALID_OUT);
        end
        vectors++;
        if (PRIMED !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_primed: got %b want 0", PRIMED);
        end
        vectors++;
        if (D_EFF !== WSEL'(1)) begin
            miscompares++;
            $display("FAIL reset_deff: got %0d want 1", D_EFF);
        end
    endtask

    task automatic test_fixed_delay();
        do_reset();
        set_sel(5);
        vectors++;
        if (D_EFF !== WSEL'(5)) begin
            miscompares++;
            $display("FAIL fixed_deff: got %0d want 5", D_EFF);
        end
        for (int i = 1; i <= 12; i++) begin
            edge_cycle(1'b1, WDATA'(i), 1'b1);
            vectors++;
            if ({OUT, VALID_OUT} !== exp_tap) begin
                miscompares++;
                $display("FAIL fixed_tap edge %0d: got %h/%b want %h/%b", i, OUT, VALID_OUT, exp_tap[WDATA:1], exp_tap[0]);
            end
            vectors++;
            if (PRIMED !== (fill >= d_cur)) begin
                miscompares++;
                $display("FAIL fixed_primed edge %0d: got %b want %b", i, PRIMED, fill >= d_cur);
            end
            if (i == 4 || i == 5) begin
                vectors++;
                if (VALID_OUT !== (i == 5) || (i == 5 && OUT !== 8'h01)) begin
                    miscompares++;
                    $display("FAIL fixed_first edge %0d: got %h/%b", i, OUT, VALID_OUT);
                end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_sel(3);
        for (int i = 0; i < 32; i++) begin
            edge_cycle((i % 2) == 0, WDATA'(8'hA0 + i / 2), 1'b1);
            vectors++;
            if ({OUT, VALID_OUT} !== exp_tap) begin
                miscompares++;
                $display("FAIL stall_tap cycle %0d: got %h/%b want %h/%b", i, OUT, VALID_OUT, exp_tap[WDATA:1], exp_tap[0]);
            end
            vectors++;
            if (PRIMED !== (fill >= d_cur)) begin
                miscompares++;
                $display("FAIL stall_primed cycle %0d: got %b want %b", i, PRIMED, fill >= d_cur);
            end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        set_sel(0);
        vectors++;
        if (D_EFF !== WSEL'(1)) begin
            miscompares++;
            $display("FAIL clamp_zero_deff: got %0d want 1", D_EFF);
        end
        for (int i = 0; i < 4; i++) begin
            edge_cycle(1'b1, WDATA'(8'h30 + i), 1'b1);
            vectors++;
            if ({OUT, VALID_OUT} !== exp_tap) begin
                miscompares++;
                $display("FAIL clamp_zero_tap %0d: got %h/%b want %h/%b", i, OUT, VALID_OUT, exp_tap[WDATA:1], exp_tap[0]);
            end
        end
        do_reset();
        SEL = WSEL'(31);
        #1;
        vectors++;
        if (D_EFF !== WSEL'(1)) begin
            miscompares++;
            $display("FAIL clamp_deff_early: got %0d want 1", D_EFF);
        end
        set_sel(31);
        vectors++;
        if (D_EFF !== WSEL'(16)) begin
            miscompares++;
            $display("FAIL clamp_max_deff: got %0d want 16", D_EFF);
        end
        for (int i = 1; i <= 20; i++) begin
            edge_cycle(1'b1, WDATA'(8'h40 + i), 1'b1);
            vectors++;
            if ({OUT, VALID_OUT} !== exp_tap || PRIMED !== (fill >= d_cur)) begin
                miscompares++;
                $display("FAIL clamp_max_tap %0d: got %h/%b/%b want %h/%b/%b", i, OUT, VALID_OUT, PRIMED, exp_tap[WDATA:1], exp_tap[0], fill >= d_cur);
            end
        end
    endtask

    task automatic test_runtime_change();
        do_reset();
        set_sel(4);
        for (int i = 1; i <= 10; i++) begin
            edge_cycle(1'b1, WDATA'(i), 1'b1);
            vectors++;
            if ({OUT, VALID_OUT} !== exp_tap) begin
                miscompares++;
                $display("FAIL change_pre_tap %0d: got %h/%b want %h/%b", i, OUT, VALID_OUT, exp_tap[WDATA:1], exp_tap[0]);
            end
        end
        // Widen to 8 while stalled: tap jumps 4 samples older (7 -> 3).
        SEL = WSEL'(8);
        CE  = 1'b0;
        @(posedge CLK);
        #1;
        vectors++;
        if (OUT !== 8'd3 || VALID_OUT !== 1'b1 || PRIMED !== 1'b1 || D_EFF !== WSEL'(8)) begin
            miscompares++;
            $display("FAIL change_jump: got %h/%b/%b/%0d want 03/1/1/8", OUT, VALID_OUT, PRIMED, D_EFF);
        end
        for (int j = 11; j <= 14; j++) begin
            CE       = 1'b1;
            IN       = WDATA'(j);
            VALID_IN = 1'b1;
            @(posedge CLK);
            #1;
            vectors++;
            if (OUT !== WDATA'(j - 7) || PRIMED !== 1'b1) begin
                miscompares++;
                $display("FAIL change_post %0d: got %h/%b want %h/1", j, OUT, PRIMED, WDATA'(j - 7));
            end
        end
        // Switching to 8 straight after reset: nothing valid for 8 CE edges.
        do_reset();
        set_sel(8);
        vectors++;
        if (PRIMED !== 1'b0 || VALID_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL change_fresh: got primed %b valid %b want 0/0", PRIMED, VALID_OUT);
        end
        for (int i = 1; i <= 10; i++) begin
            edge_cycle(1'b1, WDATA'(8'h60 + i), 1'b1);
            vectors++;
            if ({OUT, VALID_OUT} !== exp_tap || PRIMED !== (fill >= d_cur)) begin
                miscompares++;
                $display("FAIL change_fresh_tap %0d: got %h/%b/%b want %h/%b/%b", i, OUT, VALID_OUT, PRIMED, exp_tap[WDATA:1], exp_tap[0], fill >= d_cur);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_sel(3);
        for (int i = 1; i <= 5; i++) begin
            edge_cycle(1'b1, WDATA'(8'h80 + i), 1'b1);
        end
        vectors++;
        if (OUT !== 8'h83 || VALID_OUT !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_before: got %h/%b want 83/1", OUT, VALID_OUT);
        end
        RST      = 1'b1;
        CE       = 1'b1;
        IN       = 8'h77;
        VALID_IN = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        CE  = 1'b0;
        clear_model();
        // D is 1 here, so a captured 0x77 would show directly on OUT.
        vectors++;
        if (OUT !== 8'h00 || VALID_OUT !== 1'b0 || PRIMED !== 1'b0 || D_EFF !== WSEL'(1)) begin
            miscompares++;
            $display("FAIL mid_after: got %h/%b/%b/%0d want 00/0/0/1", OUT, VALID_OUT, PRIMED, D_EFF);
        end
    endtask

    task automatic test_valid_gaps();
        logic [4:0] pat;
        pat = 5'b01101; // bit0 first: 1,0,1,1,0
        do_reset();
        set_sel(2);
        for (int i = 0; i < 8; i++) begin
            edge_cycle(1'b1, WDATA'(8'h11 + i), (i < 5) ? pat[i] : 1'b0);
            vectors++;
            if ({OUT, VALID_OUT} !== exp_tap) begin
                miscompares++;
                $display("FAIL gaps_tap %0d: got %h/%b want %h/%b", i, OUT, VALID_OUT, exp_tap[WDATA:1], exp_tap[0]);
            end
        end
    endtask

    initial begin
        RST      = 1'b1;
        CE       = 1'b0;
        IN       = '0;
        VALID_IN = 1'b0;
        SEL      = '0;
        clear_model();
        test_reset();
        test_fixed_delay();
        test_stall();
        test_clamp();
        test_runtime_change();
        test_reset_mid();
        test_valid_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
